// File: rtl/png_scanline_packer_if.sv
// Pixel-in / scanline-byte-out bundle for png_scanline_packer.
// The slave side is the packer; the master side is whoever feeds pixels and takes bytes.
interface png_scanline_packer_if;
   logic [7:0]  pix_r;
   logic [7:0]  pix_g;
   logic [7:0]  pix_b;
   logic        pix_valid;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_ready;
   logic        byte_last_row;
   logic        byte_last_frame;
   logic [31:0] adler_out;
   logic        adler_valid;
   logic        overflow;

   modport slave (
      input  pix_r, pix_g, pix_b, pix_valid, byte_ready,
      output byte_data, byte_valid, byte_last_row, byte_last_frame,
      output adler_out, adler_valid, overflow
   );

   modport master (
      output pix_r, pix_g, pix_b, pix_valid, byte_ready,
      input  byte_data, byte_valid, byte_last_row, byte_last_frame,
      input  adler_out, adler_valid, overflow
   );
endinterface

// File: rtl/png_scanline_packer.sv
// Buffers RGB pixels and emits raw PNG scanlines (filter byte 0x00 + RGB per pixel)
// over valid/ready, with a running Adler-32 of every emitted byte.
module png_scanline_packer #(
   parameter int WIDTH      = 256,
   parameter int HEIGHT     = 256,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   png_scanline_packer_if.slave  bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
   localparam logic [16:0]   MOD_C    = 17'd65521;

   typedef enum logic [2:0] {S_IDLE, S_FILT, S_R, S_G, S_B, S_DONE} state_t;

   state_t          state;
   state_t          state_nx;

   logic [23:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     cnt;
   logic            empty;
   logic            full;
   logic            push;
   logic            pop;

   logic [CW-1:0]   col;
   logic [RW-1:0]   row;
   logic [7:0]      cur_g;
   logic [7:0]      cur_b;
   logic            last_row;
   logic            last_frame;
   logic            xfer;

   logic [15:0]     s1;
   logic [15:0]     s2;
   logic [15:0]     s1_nx;
   logic [15:0]     s2_nx;

   // Both operands are already reduced, so a single conditional subtract suffices.
   function automatic logic [15:0] mod_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= MOD_C)
         sum = sum - MOD_C;
      return sum[15:0];
   endfunction

   assign empty      = (cnt == '0);
   assign full       = (cnt == DEPTH_C);
   assign push       = bus.pix_valid && (!full || pop);
   assign xfer       = bus.byte_valid && bus.byte_ready;
   assign last_row   = (col == COL_LAST);
   assign last_frame = last_row && (row == ROW_LAST);

   assign s1_nx         = mod_add(s1, {8'h00, bus.byte_data});
   assign s2_nx         = mod_add(s2, s1_nx);
   assign bus.adler_out = {s2, s1};

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               if (col == '0) begin
                  state_nx = S_FILT;
               end else begin
                  state_nx = S_R;
                  pop      = 1'b1;
               end
            end
         end
         S_FILT: begin
            if (xfer) begin
               if (!empty) begin
                  state_nx = S_R;
                  pop      = 1'b1;
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end
         S_R: begin
            if (xfer)
               state_nx = S_G;
         end
         S_G: begin
            if (xfer)
               state_nx = S_B;
         end
         S_B: begin
            if (xfer) begin
               if (last_frame) begin
                  state_nx = S_DONE;
               end else if (last_row) begin
                  state_nx = empty ? S_IDLE : S_FILT;
               end else if (!empty) begin
                  state_nx = S_R;
                  pop      = 1'b1;
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Pixel storage and the G/B bytes of the pixel currently being emitted.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {bus.pix_r, bus.pix_g, bus.pix_b};
      if (pop) begin
         cur_g <= mem[rd_ptr][15:8];
         cur_b <= mem[rd_ptr][7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= S_IDLE;
         wr_ptr              <= '0;
         rd_ptr              <= '0;
         cnt                 <= '0;
         col                 <= '0;
         row                 <= '0;
         s1                  <= 16'd1;
         s2                  <= 16'd0;
         bus.byte_data       <= 8'h00;
         bus.byte_valid      <= 1'b0;
         bus.byte_last_row   <= 1'b0;
         bus.byte_last_frame <= 1'b0;
         bus.adler_valid     <= 1'b0;
         bus.overflow        <= 1'b0;
      end else begin
         state <= state_nx;

         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            cnt <= cnt + (AW+1)'(1);
         else if (pop && !push)
            cnt <= cnt - (AW+1)'(1);
         if (bus.pix_valid && full && !pop)
            bus.overflow <= 1'b1;

         if (xfer) begin
            s1 <= s1_nx;
            s2 <= s2_nx;
         end

         if (xfer && (state == S_B) && !last_frame) begin
            if (last_row) begin
               col <= '0;
               row <= row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end

         // The checksum was shown for one cycle in S_DONE; start the next frame clean.
         if (state == S_DONE) begin
            s1  <= 16'd1;
            s2  <= 16'd0;
            col <= '0;
            row <= '0;
         end

         // Byte outputs only change on a state change, which keeps them stable under stall.
         if (state_nx != state) begin
            bus.byte_valid      <= state_nx inside {S_FILT, S_R, S_G, S_B};
            bus.byte_last_row   <= 1'b0;
            bus.byte_last_frame <= 1'b0;
            case (state_nx)
               S_FILT: bus.byte_data <= 8'h00;
               S_R:    bus.byte_data <= mem[rd_ptr][23:16];
               S_G:    bus.byte_data <= cur_g;
               S_B: begin
                  bus.byte_data       <= cur_b;
                  bus.byte_last_row   <= last_row;
                  bus.byte_last_frame <= last_frame;
               end
               default: bus.byte_data <= 8'h00;
            endcase
         end

         bus.adler_valid <= (state_nx == S_DONE);
      end
   end

endmodule
